// File: rtl/pipe_pkg.sv
// Shared types and widths for the handshaked RV32I pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 96;
    localparam int CTRL_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    // Control widths of the existing stages, so each can drop in this block.
    localparam int IF_ID_CTRL_W  = 1;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int EX_MEM_CTRL_W = 10;
    localparam int MEM_WB_CTRL_W = 8;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: data, control and valid with load/clear enables.
// Latency: 1 cycle from load to output.
// Backpressure: none here; the owner decides when to load or clear.
module pipe_entry_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16
) (
    input  logic              clk_I,
    input  logic              reset_I,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    output logic              valid_q,
    output logic [DATA_W-1:0] data_q,
    output logic [CTRL_W-1:0] ctrl_q
);

    // Clear squashes control and valid but leaves data alone.
    always_ff @(posedge clk_I or negedge reset_I) begin
        if (!reset_I) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a two-entry skid buffer, flush and stall counter.
// Latency: 1 cycle input to output; 1 entry/cycle throughput while ready_I is high.
// Backpressure: ready_O is registered and drops only once main and skid are both full.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_I,
    input  logic              reset_I,
    input  logic              valid_I,
    output logic              ready_O,
    input  logic [DATA_W-1:0] data_I_D,
    input  logic [CTRL_W-1:0] ctrl_I_D,
    output logic              valid_O,
    input  logic              ready_I,
    output logic [DATA_W-1:0] data_O_Q,
    output logic [CTRL_W-1:0] ctrl_O_Q,
    input  logic              flush_I,
    input  logic              clr_cnt_I,
    output logic [CNT_W-1:0]  stall_cnt_O
);

    state_t            state;
    state_t            state_nxt;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_ld;
    logic              main_clr;
    logic              main_from_skid;
    logic              skid_ld;
    logic              skid_clr;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_dat;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic              ready_q;
    logic [CNT_W-1:0]  stall_cnt;

    assign in_xfer  = valid_I && ready_q;
    assign out_xfer = valid_O && ready_I;

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        // Flush wins; a concurrent output transfer has already been sampled downstream.
        if (flush_I) begin
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_ld   = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ld = 1'b1;
                    end else if (in_xfer) begin
                        skid_ld   = 1'b1;
                        state_nxt = FULL;
                    end else if (out_xfer) begin
                        main_clr  = 1'b1;
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign main_data_d = main_from_skid ? skid_dat  : data_I_D;
    assign main_ctrl_d = main_from_skid ? skid_ctrl : ctrl_I_D;

    always_ff @(posedge clk_I or negedge reset_I) begin
        if (!reset_I) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != FULL);
        end
    end

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk_I   (clk_I),
        .reset_I (reset_I),
        .load    (main_ld),
        .clear   (main_clr),
        .data_d  (main_data_d),
        .ctrl_d  (main_ctrl_d),
        .valid_q (valid_O),
        .data_q  (data_O_Q),
        .ctrl_q  (ctrl_O_Q)
    );

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk_I   (clk_I),
        .reset_I (reset_I),
        .load    (skid_ld),
        .clear   (skid_clr),
        .data_d  (data_I_D),
        .ctrl_d  (ctrl_I_D),
        .valid_q (skid_vld),
        .data_q  (skid_dat),
        .ctrl_q  (skid_ctrl)
    );

    // Saturating stall counter; clear beats increment.
    always_ff @(posedge clk_I or negedge reset_I) begin
        if (!reset_I) begin
            stall_cnt <= '0;
        end else if (clr_cnt_I) begin
            stall_cnt <= '0;
        end else if (valid_O && !ready_I && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign ready_O     = ready_q;
    assign stall_cnt_O = stall_cnt;

    skid_only_when_full: assert property (@(posedge clk_I) disable iff (!reset_I)
        skid_vld == (state == FULL));

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk;
    logic          reset_I;
    logic          valid_I;
    logic          ready_O;
    logic [DW-1:0] data_I_D;
    logic [CW-1:0] ctrl_I_D;
    logic          valid_O;
    logic          ready_I;
    logic [DW-1:0] data_O_Q;
    logic [CW-1:0] ctrl_O_Q;
    logic          flush_I;
    logic          clr_cnt_I;
    logic [NW-1:0] stall_cnt_O;

    ent_t exp_q[$];
    int   model_cnt;
    int   n_checks;
    int   n_fail;

    pipe_stage_skid #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk_I       (clk),
        .reset_I     (reset_I),
        .valid_I     (valid_I),
        .ready_O     (ready_O),
        .data_I_D    (data_I_D),
        .ctrl_I_D    (ctrl_I_D),
        .valid_O     (valid_O),
        .ready_I     (ready_I),
        .data_O_Q    (data_O_Q),
        .ctrl_O_Q    (ctrl_O_Q),
        .flush_I     (flush_I),
        .clr_cnt_I   (clr_cnt_I),
        .stall_cnt_O (stall_cnt_O)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] mk_ctrl(input logic [DW-1:0] d);
        return d[7:0] ^ d[15:8] ^ 8'hA5;
    endfunction

    // One cycle of stimulus; accepted entries enter the reference queue.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy,
                         input logic fl, input logic clr);
        logic acc;
        @(posedge clk);
        #1;
        valid_I   = v;
        data_I_D  = d;
        ctrl_I_D  = mk_ctrl(d);
        ready_I   = rdy;
        flush_I   = fl;
        clr_cnt_I = clr;
        @(negedge clk);
        acc = v && ready_O && !fl;
        #1;
        if (acc) exp_q.push_back('{c: mk_ctrl(d), d: d});
    endtask

    // Monitor: the stage holds exactly the accepted, undelivered, unflushed entries.
    always @(negedge clk) begin
        ent_t e;
        if (!reset_I) begin
            model_cnt = 0;
        end else begin
            chk("ready_vs_occupancy", ready_O, exp_q.size() < 2);
            chk("valid_vs_occupancy", valid_O, exp_q.size() > 0);
            chk("stall_cnt", stall_cnt_O, model_cnt);
            if (!valid_O) chk("ctrl_zero_idle", ctrl_O_Q, 0);
            if (valid_O && ready_I) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", data_O_Q, 64'hDEAD_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", data_O_Q, e.d);
                    chk("out_ctrl", ctrl_O_Q, e.c);
                end
            end
            if (flush_I) exp_q.delete();
            if (clr_cnt_I) model_cnt = 0;
            else if (valid_O && !ready_I && model_cnt < (1 << NW) - 1) model_cnt++;
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_cnt = 0;
        reset_I   = 1'b0;
        valid_I   = 1'b0;
        data_I_D  = '0;
        ctrl_I_D  = '0;
        ready_I   = 1'b0;
        flush_I   = 1'b0;
        clr_cnt_I = 1'b0;

        @(negedge clk);
        chk("rst_valid", valid_O, 0);
        chk("rst_ready", ready_O, 1);
        chk("rst_data", data_O_Q, 0);
        chk("rst_ctrl", ctrl_O_Q, 0);
        chk("rst_cnt", stall_cnt_O, 0);
        @(negedge clk);
        #2 reset_I = 1'b1;

        // Streaming 1..8 with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
            if (i > 1) chk("stream_data", data_O_Q, i - 1);
            chk("stream_ready", ready_O, 1);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("stream_last", data_O_Q, 8);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("stream_cnt", stall_cnt_O, 0);

        // Backpressure: A at head, B in skid, C held upstream
        cycle(1'b1, 'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 'hB, 1'b0, 1'b0, 1'b0);
        chk("bp_head", data_O_Q, 'hA);
        cycle(1'b1, 'hC, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_low", ready_O, 0);
        repeat (3) cycle(1'b1, 'hC, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 'hC, 1'b1, 1'b0, 1'b0);
        chk("bp_cnt", stall_cnt_O, 5);
        chk("bp_out_a", data_O_Q, 'hA);
        cycle(1'b1, 'hC, 1'b1, 1'b0, 1'b0);
        chk("bp_out_b", data_O_Q, 'hB);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp_out_c", data_O_Q, 'hC);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Flush while FULL with an entry offered upstream
        cycle(1'b1, 'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 'h22, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 'h33, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_valid", valid_O, 0);
        chk("flush_ctrl", ctrl_O_Q, 0);
        chk("flush_ready", ready_O, 1);
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'h44 + i), 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Counter saturation and clear-over-increment
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 'h77, 1'b0, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("sat_cnt", stall_cnt_O, 15);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("clr_cnt", stall_cnt_O, 0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while FULL, between clock edges
        cycle(1'b1, 'h5A, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 'h5B, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        valid_I = 1'b0;
        flush_I = 1'b0;
        clr_cnt_I = 1'b0;
        reset_I = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk("arst_valid", valid_O, 0);
        chk("arst_ready", ready_O, 1);
        chk("arst_data", data_O_Q, 0);
        chk("arst_ctrl", ctrl_O_Q, 0);
        chk("arst_cnt", stall_cnt_O, 0);
        #1 reset_I = 1'b1;
        cycle(1'b1, 'h5, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_valid", valid_O, 1);
        chk("post_rst_data", data_O_Q, 'h5);

        // Randomised traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        end
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_valid", valid_O, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
